uart_tx_buffer: RTL
===================

# uart_tx_buffer

Byte FIFO and launch controller that sits directly upstream of the UART transmit port (`UART_tx`). It accepts bytes from bench or SoC-side logic at full clock rate and drains them one at a time into the transmitter using its `dataAvailable`/`busy` handshake. Callers can then queue whole messages without polling `txBusy` per byte.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; a power of two, at least 2.
- `ACK_TIMEOUT`, 4: cycles to wait for `txBusy` to rise after a launch before flagging an error; range 1–255.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wrEnable`  in  1  push `wrData` this cycle.
- `wrData`  in  8  byte to queue.
- `flush`  in  1  discard all queued bytes.
- `pause`  in  1  hold off new launches; queued bytes are kept.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `count`  out  `$clog2(DEPTH)+1`  bytes currently queued.
- `overflow`  out  1  sticky; a write was dropped.
- `ackError`  out  1  sticky; the transmitter never asserted `txBusy` after a launch.
- `txEnable`  out  1  one-cycle launch pulse, connects to `UART_tx.dataAvailable`.
- `txData`  out  8  byte being launched, connects to `UART_tx.dataIn`.
- `txBusy`  in  1  from `UART_tx.busy`.

## Operation
- **FIFO.** Circular buffer with read and write pointers of `$clog2(DEPTH)` bits that wrap modulo `DEPTH`, plus a separate `count` register.
- **Writes.** A write is accepted when `wrEnable && !full && !flush`.
  - `wrEnable && full` drops the byte and sets `overflow`. This holds even if a pop occurs on the same edge.
- **Flush.** Zeroes both pointers and `count`, and clears `overflow`.
  - Flush wins over a simultaneous write. The dropped write does not set `overflow`.
  - Flush does not abort a byte already popped and in flight.
- **FSM states:** IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
  - IDLE → LAUNCH when `!empty && !pause && !txBusy && !flush`. On this edge: pop the FIFO, load `txData` from the head entry, set `txEnable`.
  - LAUNCH → WAIT_ACK unconditionally. `txEnable` clears on this edge, so it is high for exactly one cycle.
  - WAIT_ACK → WAIT_DONE when `txBusy` is 1.
  - WAIT_ACK → IDLE if `txBusy` is not seen within `ACK_TIMEOUT` cycles. This sets `ackError`.
  - WAIT_DONE → IDLE when `txBusy` is 0.
- **Pause.** `pause` is sampled only in IDLE. A launch already started always completes.
- **Reset values.** `rst` returns the FSM to IDLE and zeroes pointers, `count`, `txData`, `txEnable`, `overflow` and `ackError`. It is legal mid-byte; the downstream `UART_tx` shares `rst`.
  - Outputs after reset: `empty`=1, `full`=0, `count`=0.
- **Error flags.** `ackError` is cleared only by `rst`.

## Timing
- A write accepted at edge k is visible at `count`/`empty` after edge k.
- If the FSM is in IDLE with `txBusy`=0, it leaves IDLE at edge k+1.
  - `txEnable` is high from k+1 to k+2 and is sampled by `UART_tx` at edge k+2.
  - Write-to-launch latency is 2 cycles.
- `txData` is stable from the launch edge until the next launch edge.
- `count` rules per edge:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged, legal whenever not full.
  - A push to a full FIFO is dropped even if a pop happens on the same edge, so `count` goes down by 1.
- Back-to-back bytes: the next launch happens at the first edge where the FSM is in IDLE and `txBusy`=0. The minimum gap between launches is 4 cycles plus the frame time.
- Throughput is bounded by the UART. The buffer adds at most 3 cycles per byte of overhead beyond `busy` deassertion.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, LAUNCH, WAIT_ACK, WAIT_DONE);
  - the `COUNT_W` function, `$clog2(DEPTH)+1`.
- One sub-module, `byte_fifo`: storage, pointers, `count`, `full`, `empty`, overflow detection, flush.
- The FSM, launch register and timeout counter stay in `uart_tx_buffer`.
- `uart_tx_buffer` is instantiated beside `UART_tx` in bench wrappers. Wrappers use `CLK_FREQ`=100000000 and `BAUD`=115200, so `cyclesPerBit`=868.

## Test plan
- **Three-byte message.** After reset, write 0x48, 0x69, 0x0A on consecutive cycles.
  - `txEnable` pulses exactly 3 times, each for 1 cycle.
  - `txData` shows 0x48, 0x69, 0x0A in order.
  - The serial line decodes "Hi\n". `empty`=1 at the end.
- **Overflow.** With `DEPTH`=4 and `pause`=1, write 6 bytes.
  - `count`=4 and `full`=1; `overflow` sets on the 5th write.
  - Releasing `pause` transmits only the first 4 bytes.
- **Flush.** Queue 3 bytes, start one, then pulse `flush` during WAIT_DONE.
  - The in-flight byte completes.
  - `count`=0 and no further `txEnable` pulses.
- **Acknowledge timeout.** Tie `txBusy`=0 (no UART attached) and write 0x55.
  - `ackError` sets after `ACK_TIMEOUT` cycles in WAIT_ACK.
  - The FSM returns to IDLE.
- **Reset mid-byte.** Assert `rst` while in WAIT_DONE.
  - On the next edge: `txEnable`=0, `count`=0, `empty`=1, both flags 0.
  - A subsequent write of 0xA5 transmits correctly.
- **Full-FIFO push/pop.** Write while full on the same edge as a pop.
  - The write is dropped, `overflow` sets, and `count` decreases by 1.

Source files
------------

// File: rtl/uart_tx_buffer_pkg.sv
// Shared types and sizing helpers for the UART transmit buffer.
package uart_tx_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int COUNT_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_buffer_byte_fifo.sv
// Circular byte FIFO with occupancy count, sticky overflow and synchronous flush.
module byte_fifo
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [7:0]                 head,
    output logic                       full,
    output logic                       empty,
    output logic [COUNT_W(DEPTH)-1:0]  count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = COUNT_W(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
            if (push && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte queue plus launch controller feeding a UART transmitter through its
// dataAvailable/busy handshake, with an acknowledge timeout.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wrEnable,
    input  logic [7:0]                 wrData,
    input  logic                       flush,
    input  logic                       pause,
    output logic                       full,
    output logic                       empty,
    output logic [COUNT_W(DEPTH)-1:0]  count,
    output logic                       overflow,
    output logic                       ackError,
    output logic                       txEnable,
    output logic [7:0]                 txData,
    input  logic                       txBusy
);

    tx_state_t  state_q;
    tx_state_t  state_d;
    logic [7:0] timer_q;
    logic [7:0] timer_d;
    logic [7:0] tx_data_d;
    logic       tx_enable_d;
    logic       ack_error_d;
    logic       pop;
    logic [7:0] head;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wrEnable),
        .push_data (wrData),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    // The ack timer counts down from ACK_TIMEOUT-1 so WAIT_ACK lasts ACK_TIMEOUT cycles.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        tx_data_d   = txData;
        tx_enable_d = 1'b0;
        ack_error_d = ackError;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && !pause && !txBusy && !flush) begin
                    state_d     = LAUNCH;
                    pop         = 1'b1;
                    tx_data_d   = head;
                    tx_enable_d = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = WAIT_ACK;
                timer_d = 8'(ACK_TIMEOUT - 1);
            end
            WAIT_ACK: begin
                if (txBusy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == '0) begin
                    state_d     = IDLE;
                    ack_error_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!txBusy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            txData   <= '0;
            txEnable <= 1'b0;
            ackError <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            txData   <= tx_data_d;
            txEnable <= tx_enable_d;
            ackError <= ack_error_d;
        end
    end

endmodule
